// File: rtl/genius_game_ctrl.sv
// genius_game_ctrl: Simon-style sequence builder, LED playback and remote-press checker
module genius_game_ctrl #(
  parameter int MAX_LEN        = 16,
  parameter int SHOW_CYCLES    = 25_000_000,
  parameter int GAP_CYCLES     = 12_500_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic       clk_pll,
  input  logic       reset,
  input  logic [1:0] cor,
  input  logic [2:0] botao,
  input  logic       ready,
  output logic [3:0] led,
  output logic [4:0] level,
  output logic       busy,
  output logic       game_over,
  output logic       win
);
  localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  typedef enum logic [2:0] {IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN, WON, LOST} state_t;
  state_t state, state_n;
  logic [1:0] mem [MAX_LEN];
  logic [4:0] idx, idx_n, level_n;
  logic [27:0] timer;
  logic rdy_q, evt, is_start, is_col, last, tmr_clr;
  logic [1:0] col, cur;
  assign evt = ready & ~rdy_q;
  assign is_start = botao == 3'b100;
  assign is_col = botao == 3'b011 || botao == 3'b110 || botao == 3'b010 || botao == 3'b001;
  assign col = botao == 3'b011 ? 2'd0 : botao == 3'b110 ? 2'd1 : botao == 3'b010 ? 2'd2 : 2'd3;
  assign cur = mem[idx[IW-1:0]];
  assign last = idx == level - 5'd1;
  always_comb begin
    state_n = state;
    idx_n = idx;
    level_n = level;
    tmr_clr = 1'b0;
    case (state)
      IDLE, WON, LOST: if (evt && is_start) begin
        level_n = '0;
        state_n = ADD;
      end
      ADD: begin
        level_n = level + 5'd1;
        idx_n = '0;
        state_n = SHOW_ON;
      end
      SHOW_ON: if (timer == 28'(SHOW_CYCLES - 1)) state_n = SHOW_OFF;
      SHOW_OFF: if (timer == 28'(GAP_CYCLES - 1)) begin
        idx_n = last ? 5'd0 : idx + 5'd1;
        state_n = last ? WAIT_IN : SHOW_ON;
      end
      WAIT_IN: if (evt && is_col) begin
        if (col != cur) state_n = LOST;
        else if (last) state_n = level == 5'(MAX_LEN) ? WON : ADD;
        else begin
          idx_n = idx + 5'd1;
          tmr_clr = 1'b1;
        end
      end else if (timer == 28'(TIMEOUT_CYCLES - 1)) state_n = LOST;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_pll or negedge reset)
    if (!reset) begin
      state <= IDLE;
      idx <= '0;
      level <= '0;
      timer <= '0;
      rdy_q <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      level <= level_n;
      timer <= (state_n != state || tmr_clr) ? 28'd0 : timer + 28'd1;
      rdy_q <= ready;
    end
  // Sequence storage survives reset; only entries below level are ever read.
  always_ff @(posedge clk_pll)
    if (state == ADD) mem[level[IW-1:0]] <= cor;
  assign led = state == SHOW_ON ? 4'b0001 << cur : state == WON ? 4'b1010 : state == LOST ? 4'b1111 : 4'b0000;
  assign busy = state == ADD || state == SHOW_ON || state == SHOW_OFF;
  assign game_over = state == LOST;
  assign win = state == WON;
endmodule

// File: tb/tb_genius_game_ctrl.sv
// tb_genius_game_ctrl: directed scenarios with an expected-output queue for genius_game_ctrl
module tb_genius_game_ctrl;
  logic clk = 1'b0, reset = 1'b0, ready = 1'b0;
  logic [1:0] cor = '0;
  logic [2:0] botao = '0;
  logic [3:0] led;
  logic [4:0] level;
  logic busy, game_over, win;
  int tests = 0, fails = 0;
  typedef struct {string tag; logic [11:0] v;} exp_t;
  exp_t sb[$];

  genius_game_ctrl #(.MAX_LEN(3), .SHOW_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(50)) dut (
    .clk_pll(clk), .reset(reset), .cor(cor), .botao(botao), .ready(ready),
    .led(led), .level(level), .busy(busy), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] pk(logic [3:0] l, logic [4:0] lv, logic b, logic g, logic w);
    return {l, lv, b, g, w};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [11:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic cmp();
    exp_t e;
    logic [11:0] obs;
    e = sb.pop_front();
    obs = {led, level, busy, game_over, win};
    tests++;
    assert (obs === e.v) else begin
      fails++;
      $error("FAIL %s: got led=%b level=%0d busy=%b go=%b win=%b, want led=%b level=%0d busy=%b go=%b win=%b",
             e.tag, obs[11:8], obs[7:3], obs[2], obs[1], obs[0], e.v[11:8], e.v[7:3], e.v[2], e.v[1], e.v[0]);
    end
  endtask

  task automatic chk(input string tag, input logic [11:0] v);
    push(tag, v);
    cmp();
  endtask

  task automatic evt(input logic [2:0] code);
    botao = code;
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  // Expects one playback of n colours starting from the cycle after ADD, ending in WAIT_IN.
  task automatic play(input int n, input logic [5:0] cols);
    logic [1:0] c;
    for (int k = 0; k < n; k++) begin
      c = cols[2*k +: 2];
      repeat (4) push("show_on", pk(4'b0001 << c, 5'(n), 1, 0, 0));
      repeat (2) push("show_off", pk(4'b0000, 5'(n), 1, 0, 0));
    end
    push("wait_in", pk(4'b0000, 5'(n), 0, 0, 0));
    repeat (6 * n + 1) begin
      tick(1);
      cmp();
    end
  endtask

  initial begin
    #2 chk("reset", pk(0, 0, 0, 0, 0));
    reset = 1'b1;
    tick(2);
    chk("idle", pk(0, 0, 0, 0, 0));
    cor = 2'd2;
    evt(3'b100);
    chk("add1", pk(0, 0, 1, 0, 0));
    play(1, 6'b000010);
    cor = 2'd1;
    evt(3'b010);
    chk("add2", pk(0, 1, 1, 0, 0));
    play(2, 6'b000110);
    evt(3'b010);
    chk("press_ok", pk(0, 2, 0, 0, 0));
    tick(1);
    cor = 2'd0;
    evt(3'b110);
    chk("add3", pk(0, 2, 1, 0, 0));
    play(3, 6'b000110);
    evt(3'b010);
    tick(1);
    evt(3'b110);
    tick(1);
    evt(3'b011);
    chk("win", pk(4'b1010, 3, 0, 0, 1));
    tick(1);
    cor = 2'd1;
    evt(3'b100);
    chk("restart", pk(0, 0, 1, 0, 0));
    play(1, 6'b000001);
    cor = 2'd3;
    evt(3'b110);
    chk("add_l2", pk(0, 1, 1, 0, 0));
    play(2, 6'b001101);
    evt(3'b110);
    chk("first_ok", pk(0, 2, 0, 0, 0));
    tick(1);
    evt(3'b010);
    chk("lose_wrong", pk(4'b1111, 2, 0, 1, 0));
    tick(1);
    evt(3'b001);
    chk("lose_hold", pk(4'b1111, 2, 0, 1, 0));
    tick(1);
    cor = 2'd0;
    evt(3'b100);
    chk("add_to", pk(0, 0, 1, 0, 0));
    play(1, 6'b000000);
    tick(49);
    chk("before_to", pk(0, 1, 0, 0, 0));
    tick(1);
    chk("timeout", pk(4'b1111, 1, 0, 1, 0));
    cor = 2'd2;
    evt(3'b100);
    chk("add_edge", pk(0, 0, 1, 0, 0));
    play(1, 6'b000010);
    tick(49);
    chk("edge_wait", pk(0, 1, 0, 0, 0));
    cor = 2'd3;
    evt(3'b010);
    chk("evt_beats_to", pk(0, 1, 1, 0, 0));
    play(2, 6'b001110);
    botao = 3'b010;
    ready = 1'b1;
    tick(10);
    ready = 1'b0;
    chk("held_ready", pk(0, 2, 0, 0, 0));
    tick(1);
    evt(3'b000);
    chk("code000", pk(0, 2, 0, 0, 0));
    tick(1);
    evt(3'b111);
    chk("code111", pk(0, 2, 0, 0, 0));
    tick(1);
    cor = 2'd0;
    evt(3'b001);
    chk("add_last", pk(0, 2, 1, 0, 0));
    tick(1);
    chk("show_start", pk(4'b0100, 3, 1, 0, 0));
    evt(3'b011);
    chk("drop_press", pk(4'b0100, 3, 1, 0, 0));
    tick(1);
    chk("drop_press2", pk(4'b0100, 3, 1, 0, 0));
    #2 reset = 1'b0;
    #1 chk("async_reset", pk(0, 0, 0, 0, 0));
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("post_reset", pk(0, 0, 0, 0, 0));
    evt(3'b100);
    chk("start_again", pk(0, 0, 1, 0, 0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
